// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD receive-side monitor.
//   - lcd_state_e : monitor synchronisation state (SEARCH / SYNCED)
//   - DEF_*       : default panel geometry and counter width
//   - SUM_W       : width of the per-frame pixel checksum
package lcd_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    SYNCED = 1'b1
  } lcd_state_e;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_CNT_W    = 11;
  localparam int unsigned SUM_W        = 16;

endpackage

// File: rtl/lcd_edge_det.sv
// lcd_edge_det: registered edge detector with sample enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : sample enable; the stored previous value only advances when en = 1
//   d          : signal under observation
//   rise, fall : single-cycle pulses, valid only in cycles where en = 1
// With en tied high this compares consecutive clock cycles; with en driven
// by a strobe it compares consecutive strobe samples.
module lcd_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = prev_q;
    if (en) prev_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = en &  d & ~prev_q;
  assign fall = en & ~d &  prev_q;

endmodule

// File: rtl/lcd_rx_monitor.sv
// lcd_rx_monitor: receive-side checker for a parallel RGB LCD panel interface.
// Samples NCLK/GREST/HD/VD/DEN/RGB in the CLK domain on each NCLK rising edge,
// rebuilds pixel coordinates, measures line length and frame height and keeps
// a per-frame 16-bit pixel checksum.
//   CLK, RST_n          : system clock, asynchronous active-low reset
//   NCLK                : pixel clock (period >= 2 CLK), sampled on its rising edge
//   GREST, HD, VD       : active-low panel reset / horizontal / vertical sync
//   DEN, R, G, B        : data enable and pixel colour
//   PIX_*               : captured pixel, PIX_VALID pulses one CLK per active pixel
//   LINE_LEN            : DEN count of the last completed line
//   FRAME_LINES/SUM     : line count and checksum of the last committed frame
//   FRAME_DONE          : one-CLK pulse when frame results commit
//   ERR_H, ERR_V, LOCKED: geometry error flags of the last committed frame
//   dbg_state           : current synchronisation state
// Output handshake: PIX_VALID and FRAME_DONE are valid-only pulses with no
// back-pressure; their associated data outputs are stable in the pulse cycle
// and hold until the next event.
module lcd_rx_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             NCLK,
  input  logic             GREST,
  input  logic             HD,
  input  logic             VD,
  input  logic             DEN,
  input  logic [7:0]       R,
  input  logic [7:0]       G,
  input  logic [7:0]       B,
  output logic             PIX_VALID,
  output logic [CNT_W-1:0] PIX_X,
  output logic [CNT_W-1:0] PIX_Y,
  output logic [7:0]       PIX_R,
  output logic [7:0]       PIX_G,
  output logic [7:0]       PIX_B,
  output logic [CNT_W-1:0] LINE_LEN,
  output logic [CNT_W-1:0] FRAME_LINES,
  output logic [SUM_W-1:0] FRAME_SUM,
  output logic             FRAME_DONE,
  output logic             ERR_H,
  output logic             ERR_V,
  output logic             LOCKED,
  output lcd_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic pst, hd_fall, vd_fall;
  logic nclk_fall, hd_rise, vd_rise;
  logic unused_edges;
  assign unused_edges = ^{nclk_fall, hd_rise, vd_rise};

  lcd_edge_det u_nclk_det (.clk(CLK), .rst_n(RST_n), .en(1'b1), .d(NCLK),
                           .rise(pst), .fall(nclk_fall));
  lcd_edge_det u_hd_det   (.clk(CLK), .rst_n(RST_n), .en(pst), .d(HD),
                           .rise(hd_rise), .fall(hd_fall));
  lcd_edge_det u_vd_det   (.clk(CLK), .rst_n(RST_n), .en(pst), .d(VD),
                           .rise(vd_rise), .fall(vd_fall));

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             acc_q, acc_d;
  logic             pix_valid_q, pix_valid_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]       pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;
  logic             frame_done_q, frame_done_d;
  logic             err_h_q, err_h_d, err_v_q, err_v_d, locked_q, locked_d;

  // Within one strobe sample the order is: line close, frame commit, pixel
  // capture. So a line closed on a VD sample belongs to the committed frame,
  // and a DEN pixel on an HD-fall sample starts the new line at X = 0.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    sum_d         = sum_q;
    acc_d         = acc_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_sum_d   = frame_sum_q;
    frame_done_d  = 1'b0;
    err_h_d       = err_h_q;
    err_v_d       = err_v_q;
    locked_d      = locked_q;

    if (pst) begin
      if (!GREST) begin
        // Panel reset: drop sync, keep committed results.
        state_d  = SEARCH;
        x_d      = '0;
        y_d      = '0;
        sum_d    = '0;
        acc_d    = 1'b0;
        locked_d = 1'b0;
      end else if (state_q == SEARCH) begin
        if (vd_fall) begin
          state_d = SYNCED;
          x_d     = '0;
          y_d     = '0;
          sum_d   = '0;
          acc_d   = 1'b0;
        end
      end else begin
        if (hd_fall) begin
          // A line without any DEN pixel is not a line.
          if (x_q != '0) begin
            line_len_d = x_q;
            y_d        = sat_inc(y_q);
            acc_d      = acc_q | (x_q != H_EXP);
          end
          x_d = '0;
        end
        if (vd_fall) begin
          frame_lines_d = y_d;
          frame_sum_d   = sum_d;
          err_h_d       = acc_d;
          err_v_d       = (y_d != V_EXP);
          locked_d      = !(acc_d || (y_d != V_EXP));
          frame_done_d  = 1'b1;
          x_d           = '0;
          y_d           = '0;
          sum_d         = '0;
          acc_d         = 1'b0;
        end
        if (DEN) begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_d;
          pix_y_d     = y_d;
          pix_r_d     = R;
          pix_g_d     = G;
          pix_b_d     = B;
          x_d         = sat_inc(x_d);
          sum_d       = sum_d + SUM_W'(R) + SUM_W'(G) + SUM_W'(B);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= SEARCH;
      x_q           <= '0;
      y_q           <= '0;
      sum_q         <= '0;
      acc_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_sum_q   <= '0;
      frame_done_q  <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sum_q         <= sum_d;
      acc_q         <= acc_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_sum_q   <= frame_sum_d;
      frame_done_q  <= frame_done_d;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
      locked_q      <= locked_d;
    end
  end

  assign PIX_VALID   = pix_valid_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign PIX_R       = pix_r_q;
  assign PIX_G       = pix_g_q;
  assign PIX_B       = pix_b_q;
  assign LINE_LEN    = line_len_q;
  assign FRAME_LINES = frame_lines_q;
  assign FRAME_SUM   = frame_sum_q;
  assign FRAME_DONE  = frame_done_q;
  assign ERR_H       = err_h_q;
  assign ERR_V       = err_v_q;
  assign LOCKED      = locked_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/lcd_rx_monitor.md
Name: lcd_rx_monitor

Overview:
- Receive-side counterpart of the colour-bar LCD timing generator.
- Samples the panel interface (NCLK, GREST, HD, VD, DEN, R, G, B) in the system CLK domain and reconstructs pixel coordinates.
- Measures line length and frame height, flags deviations from the expected geometry, and produces a per-frame pixel checksum.
- Sits beside the generator as an in-system checker and as a self-checking bench monitor.

Parameters:
- H_ACTIVE, 800: expected DEN-high pixels per line.
- V_ACTIVE, 480: expected active lines per frame.
- CNT_W, 11: width of the X/Y and measurement counters.

Ports:
- CLK  in  1  system clock; NCLK is derived from it with period >= 2 CLK.
- RST_n  in  1  reset, asynchronous, active-low.
- NCLK  in  1  pixel clock from the generator; data is sampled on its rising edge.
- GREST  in  1  panel global reset, active-low.
- HD  in  1  horizontal sync, active-low.
- VD  in  1  vertical sync, active-low.
- DEN  in  1  data enable, active-high.
- R, G, B  in  8 each  pixel colour.
- PIX_VALID  out  1  one-CLK pulse per captured active pixel.
- PIX_X, PIX_Y  out  CNT_W each  coordinate of the captured pixel.
- PIX_R, PIX_G, PIX_B  out  8 each  captured colour.
- LINE_LEN  out  CNT_W  DEN count of the last completed line.
- FRAME_LINES  out  CNT_W  active lines in the last completed frame.
- FRAME_SUM  out  16  checksum of the last completed frame.
- FRAME_DONE  out  1  one-CLK pulse when frame results commit.
- ERR_H  out  1  some line in the last frame had LINE_LEN != H_ACTIVE.
- ERR_V  out  1  FRAME_LINES != V_ACTIVE.
- LOCKED  out  1  last committed frame was error-free.

Behaviour:
- Reset: every output and internal register is 0 immediately on RST_n low. State is SEARCH.
- Pixel strobe: pst = NCLK & ~NCLK_q, where NCLK_q is NCLK registered on CLK. HD, VD, DEN and RGB are sampled in the CLK cycle where pst = 1. All other cycles are ignored.
- Edge detection: HD and VD falling edges are detected between consecutive strobe samples, not between CLK cycles.
- States:
  - SEARCH: no PIX_VALID, counters held at 0. A VD falling edge moves to SYNCED and clears X, Y, sum and the error accumulators. No FRAME_DONE is produced.
  - SYNCED, strobe with DEN = 1: one CLK after the strobe, PIX_VALID = 1 with PIX_X/PIX_Y = current X/Y and the captured RGB. Then X += 1, saturating at 2^CNT_W-1. sum = (sum + R + G + B) mod 2^16.
  - SYNCED, HD falling edge: if X > 0, LINE_LEN <= X, Y += 1 (saturating), and ERR_H accumulates (X != H_ACTIVE). Then X <= 0. A line with no DEN is not counted.
  - SYNCED, VD falling edge: commit the frame. FRAME_LINES <= Y, FRAME_SUM <= sum, ERR_H <= accumulator, ERR_V <= (Y != V_ACTIVE), LOCKED <= no error, FRAME_DONE pulses for 1 CLK. Then clear X, Y, sum and the accumulator.
- Simultaneous HD and VD fall in the same sample: line close first, then frame commit. The closing line counts in the committed frame.
- DEN = 1 on the same sample as an HD fall: the line closes first, and the pixel is counted as X = 0 of the new line.
- GREST = 0 on any strobe sample: return to SEARCH, clear X/Y/sum/accumulators, LOCKED <= 0. Committed results (LINE_LEN, FRAME_*, ERR_*) hold.
- Registered outputs hold their value between events. PIX_R/G/B and PIX_X/Y hold their last value after PIX_VALID falls.
- Latency: strobe cycle to PIX_VALID is 1 CLK. VD fall sample to FRAME_DONE is 1 CLK.

Decomposition:
- Package lcd_pkg:
  - state encoding SEARCH/SYNCED.
  - default H_ACTIVE/V_ACTIVE/CNT_W.
  - checksum width constant (16).
- Sub-module lcd_edge_det: registered previous value, outputs rise/fall pulses, with an optional enable.
  - Instantiated for NCLK (enable = 1).
  - Instantiated for HD and VD (enable = pst).

Test Plan:
- Assert RST_n = 0 mid-line with stimulus running -> all outputs 0 the same instant; after release, no PIX_VALID until the first VD fall.
- Params H_ACTIVE = 4, V_ACTIVE = 2; drive two frames of 2 lines x 4 pixels, all RGB = 255 -> on the second VD fall:
  - FRAME_DONE = 1 for 1 CLK;
  - LINE_LEN = 4, FRAME_LINES = 2, FRAME_SUM = 0x17E8;
  - ERR_H = 0, ERR_V = 0, LOCKED = 1;
  - 8 PIX_VALID pulses at (0,0)..(3,1).
- Same frame with line 1 at 3 pixels -> LINE_LEN = 3, ERR_H = 1, ERR_V = 0, LOCKED = 0, FRAME_SUM = 0x14EB.
- Frame with 3 active lines plus one DEN-free line -> FRAME_LINES = 3, ERR_V = 1; the blank line is not counted.
- HD and VD falling on the same sample after line 2 -> FRAME_LINES = 2 and LINE_LEN = 4 for that line.
- GREST = 0 pulsed mid-frame -> LOCKED = 0, no FRAME_DONE at the next VD fall (resync only), FRAME_DONE on the VD fall after that.
